multicycle_controller: RTL and testbench

//  Multi-cycle sequencing FSM for the RV32 datapath.

---
 rtl/multicycle_controller.sv | 225 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32 datapath sharing one memory port.
// Drives datapath strobes, counts retired instructions and traps on illegal opcodes or memory timeouts.
//
// state  | meaning
// FETCH  | instruction read on the shared port; IR latched on mem_ready
// DECODE | opcode class registered; illegal opcode traps
// EXEC   | ALU operation; branches resolve and retire here
// MEM    | data read/write held until mem_ready; stores retire here
// WB     | register write-back and PC+4; R/I/LD retire here
// TRAP   | all strobes idle until reset
module multicycle_controller #(
  parameter int MEM_WAIT_MAX  = 16,
  parameter int INSTRET_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [6:0]               opcode,
  input  logic                     zero,
  input  logic                     mem_ready,
  output logic                     mem_req,
  output logic                     mem_is_instr,
  output logic                     memoryRead,
  output logic                     memoryWrite,
  output logic                     ir_write,
  output logic                     pc_write,
  output logic                     pc_branch,
  output logic                     rWrite,
  output logic                     memoryToRegister,
  output logic                     ALUSrc,
  output logic [1:0]               ALUOp,
  output logic [2:0]               state,
  output logic                     illegal,
  output logic                     timeout,
  output logic [INSTRET_WIDTH-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_NONE = 3'd0,
    C_R    = 3'd1,
    C_I    = 3'd2,
    C_LD   = 3'd3,
    C_ST   = 3'd4,
    C_BR   = 3'd5,
    C_ILL  = 3'd6
  } class_t;

  localparam int WCW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_WAIT_MAX - 1);

  state_t   state_q, state_n;
  class_t   class_q, dec_class;
  logic [WCW-1:0] wait_cnt;
  logic     mem_phase;
  logic     wait_expire;
  logic     retire;
  logic     set_ill;
  logic     set_to;

  always_comb begin
    dec_class = C_ILL;
    case (opcode)
      7'b0110011: dec_class = C_R;
      7'b0010011: dec_class = C_I;
      7'b0000011: dec_class = C_LD;
      7'b0100011: dec_class = C_ST;
      7'b1100011: dec_class = C_BR;
      default:    dec_class = C_ILL;
    endcase
  end

  assign mem_phase   = (state_q == S_FETCH) || (state_q == S_MEM);
  // A ready arriving in the last allowed cycle wins over the timeout.
  assign wait_expire = mem_phase && !mem_ready && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      class_q  <= C_NONE;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
      instret  <= '0;
    end else begin
      state_q <= state_n;
      if (state_q == S_DECODE) class_q <= dec_class;
      if (!mem_phase || (state_n != state_q)) wait_cnt <= '0;
      else if (!mem_ready) wait_cnt <= wait_cnt + WCW'(1);
      if (set_ill) illegal <= 1'b1;
      if (set_to) timeout <= 1'b1;
      if (retire) instret <= instret + INSTRET_WIDTH'(1);
    end
  end

  always_comb begin
    state_n = state_q;
    retire  = 1'b0;
    set_ill = 1'b0;
    set_to  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_n = S_DECODE;
        else if (wait_expire) begin
          state_n = S_TRAP;
          set_to  = 1'b1;
        end
      end
      S_DECODE: begin
        if (dec_class == C_ILL) begin
          state_n = S_TRAP;
          set_ill = 1'b1;
        end else begin
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        case (class_q)
          C_R, C_I:   state_n = S_WB;
          C_LD, C_ST: state_n = S_MEM;
          C_BR: begin
            state_n = S_FETCH;
            retire  = 1'b1;
          end
          default:    state_n = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (class_q == C_LD) state_n = S_WB;
          else begin
            state_n = S_FETCH;
            retire  = 1'b1;
          end
        end else if (wait_expire) begin
          state_n = S_TRAP;
          set_to  = 1'b1;
        end
      end
      S_WB: begin
        state_n = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:  state_n = S_TRAP;
      default: state_n = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req          = 1'b0;
    mem_is_instr     = 1'b0;
    memoryRead       = 1'b0;
    memoryWrite      = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    pc_branch        = 1'b0;
    rWrite           = 1'b0;
    memoryToRegister = 1'b0;
    ALUSrc           = 1'b0;
    ALUOp            = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req      = 1'b1;
        mem_is_instr = 1'b1;
        memoryRead   = 1'b1;
        ir_write     = mem_ready;
      end
      S_EXEC: begin
        case (class_q)
          C_R: ALUOp = 2'b10;
          C_I: begin
            ALUOp  = 2'b10;
            ALUSrc = 1'b1;
          end
          C_LD, C_ST: ALUSrc = 1'b1;
          C_BR: begin
            ALUOp     = 2'b01;
            pc_write  = 1'b1;
            pc_branch = zero;
          end
          default: ALUOp = 2'b00;
        endcase
      end
      S_MEM: begin
        mem_req     = 1'b1;
        ALUSrc      = 1'b1;
        memoryRead  = (class_q == C_LD);
        memoryWrite = (class_q == C_ST);
        pc_write    = mem_ready && (class_q == C_ST);
      end
      S_WB: begin
        rWrite           = 1'b1;
        pc_write         = 1'b1;
        memoryToRegister = (class_q == C_LD);
        ALUOp            = (class_q == C_LD) ? 2'b00 : 2'b10;
        ALUSrc           = (class_q != C_R);
      end
      default: ALUOp = 2'b00;
    endcase
    // Reset is asynchronous, so strobes must fall without waiting for a clock edge.
    if (!reset) begin
      mem_req          = 1'b0;
      mem_is_instr     = 1'b0;
      memoryRead       = 1'b0;
      memoryWrite      = 1'b0;
      ir_write         = 1'b0;
      pc_write         = 1'b0;
      pc_branch        = 1'b0;
      rWrite           = 1'b0;
      memoryToRegister = 1'b0;
      ALUSrc           = 1'b0;
      ALUOp            = 2'b00;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scoreboard bench for multicycle_controller: per-cycle stimulus and expected outputs
// are queued per instruction, then replayed and compared cycle by cycle.
module tb_multicycle_controller;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_XX = 7'b1111111;
  localparam int CR = 0, CI = 1, CLD = 2, CST = 3, CBR = 4;

  logic clock = 1'b0;
  logic reset;
  logic [6:0] opcode;
  logic zero, mem_ready;
  logic mem_req, mem_is_instr, memoryRead, memoryWrite, ir_write, pc_write, pc_branch;
  logic rWrite, memoryToRegister, ALUSrc, illegal, timeout;
  logic [1:0] ALUOp;
  logic [2:0] state;
  logic [31:0] instret;

  logic mem_req2, mem_is_instr2, memoryRead2, memoryWrite2, ir_write2, pc_write2, pc_branch2;
  logic rWrite2, memoryToRegister2, ALUSrc2, illegal2, timeout2;
  logic [1:0] ALUOp2;
  logic [2:0] state2;
  logic [1:0] instret2;

  multicycle_controller #(.MEM_WAIT_MAX(16), .INSTRET_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_is_instr(mem_is_instr), .memoryRead(memoryRead),
    .memoryWrite(memoryWrite), .ir_write(ir_write), .pc_write(pc_write),
    .pc_branch(pc_branch), .rWrite(rWrite), .memoryToRegister(memoryToRegister),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp), .state(state), .illegal(illegal),
    .timeout(timeout), .instret(instret)
  );

  // Narrow counter instance exposes the instret wrap after four retirements.
  multicycle_controller #(.MEM_WAIT_MAX(16), .INSTRET_WIDTH(2)) dut_wrap (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req2), .mem_is_instr(mem_is_instr2), .memoryRead(memoryRead2),
    .memoryWrite(memoryWrite2), .ir_write(ir_write2), .pc_write(pc_write2),
    .pc_branch(pc_branch2), .rWrite(rWrite2), .memoryToRegister(memoryToRegister2),
    .ALUSrc(ALUSrc2), .ALUOp(ALUOp2), .state(state2), .illegal(illegal2),
    .timeout(timeout2), .instret(instret2)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0]  st;
    logic        req, instr, rd, wr, irw, pcw, pcb, rw, m2r, asrc;
    logic [1:0]  aop;
    logic        ill, to;
    logic [31:0] ir;
  } obs_t;

  typedef struct packed {
    logic       rdy;
    logic [6:0] op;
    logic       z;
    obs_t       e;
  } item_t;

  item_t sb[$];
  int checks = 0;
  int fails = 0;
  int cyc_idx = 0;
  string cur_tag = "init";
  logic [31:0] exp_ret;
  logic exp_ill, exp_to;

  function automatic obs_t observed();
    obs_t g;
    g = {state, mem_req, mem_is_instr, memoryRead, memoryWrite, ir_write, pc_write,
         pc_branch, rWrite, memoryToRegister, ALUSrc, ALUOp, illegal, timeout, instret};
    return g;
  endfunction

  function automatic obs_t base(input logic [2:0] st);
    obs_t o;
    o = '0;
    o.st = st;
    o.ill = exp_ill;
    o.to = exp_to;
    o.ir = exp_ret;
    return o;
  endfunction

  function automatic obs_t e_fetch(input logic rdy);
    obs_t o;
    o = base(3'd0);
    o.req = 1'b1; o.instr = 1'b1; o.rd = 1'b1; o.irw = rdy;
    return o;
  endfunction

  function automatic obs_t e_exec(input int cls, input logic z);
    obs_t o;
    o = base(3'd2);
    case (cls)
      CR:       begin o.aop = 2'b10; o.asrc = 1'b0; end
      CI:       begin o.aop = 2'b10; o.asrc = 1'b1; end
      CLD, CST: begin o.aop = 2'b00; o.asrc = 1'b1; end
      default:  begin o.aop = 2'b01; o.asrc = 1'b0; o.pcw = 1'b1; o.pcb = z; end
    endcase
    return o;
  endfunction

  function automatic obs_t e_mem(input int cls, input logic rdy);
    obs_t o;
    o = base(3'd3);
    o.req = 1'b1; o.asrc = 1'b1; o.aop = 2'b00;
    o.rd = (cls == CLD);
    o.wr = (cls == CST);
    o.pcw = (cls == CST) && rdy;
    return o;
  endfunction

  function automatic obs_t e_wb(input int cls);
    obs_t o;
    o = base(3'd4);
    o.rw = 1'b1; o.pcw = 1'b1;
    o.m2r = (cls == CLD);
    o.aop = (cls == CLD) ? 2'b00 : 2'b10;
    o.asrc = (cls != CR);
    return o;
  endfunction

  task automatic push(input logic rdy, input logic [6:0] op, input logic z, input obs_t e);
    item_t it;
    it.rdy = rdy; it.op = op; it.z = z; it.e = e;
    sb.push_back(it);
  endtask

  task automatic chk(input obs_t e);
    obs_t g;
    g = observed();
    checks++;
    assert (g === e) else begin
      fails++;
      $error("FAIL %s cyc%0d observed=%h expected=%h", cur_tag, cyc_idx, g, e);
    end
    checks++;
    assert ({state2, instret2} === {e.st, e.ir[1:0]}) else begin
      fails++;
      $error("FAIL %s_wrap cyc%0d observed=%h expected=%h", cur_tag, cyc_idx,
             {state2, instret2}, {e.st, e.ir[1:0]});
    end
  endtask

  task automatic drain();
    item_t it;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      mem_ready = it.rdy;
      opcode = it.op;
      zero = it.z;
      #1;
      chk(it.e);
      cyc_idx++;
      @(negedge clock);
    end
  endtask

  task automatic do_instr(input logic [6:0] op, input int cls, input logic z,
                          input int fwait, input int mwait, input string tag);
    cur_tag = tag;
    cyc_idx = 0;
    repeat (fwait) push(1'b0, op, z, e_fetch(1'b0));
    push(1'b1, op, z, e_fetch(1'b1));
    push(1'b1, op, z, base(3'd1));
    push(1'b1, op, z, e_exec(cls, z));
    if (cls == CLD || cls == CST) begin
      repeat (mwait) push(1'b0, op, z, e_mem(cls, 1'b0));
      push(1'b1, op, z, e_mem(cls, 1'b1));
      if (cls == CLD) push(1'b1, op, z, e_wb(cls));
    end else if (cls != CBR) begin
      push(1'b1, op, z, e_wb(cls));
    end
    drain();
    exp_ret = exp_ret + 32'd1;
  endtask

  task automatic reset_pulse(input string tag);
    cur_tag = tag;
    reset = 1'b0;
    exp_ret = '0; exp_ill = 1'b0; exp_to = 1'b0;
    #1;
    chk(base(3'd0));
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; mem_ready = 1'b0; opcode = OP_R; zero = 1'b0;
    exp_ret = '0; exp_ill = 1'b0; exp_to = 1'b0;

    @(negedge clock);
    cur_tag = "reset_hold";
    mem_ready = 1'b1;
    #1;
    chk(base(3'd0));
    @(negedge clock);
    reset = 1'b1;

    do_instr(OP_R,  CR,  1'b0, 0, 0, "r_type");
    do_instr(OP_LD, CLD, 1'b0, 0, 3, "ld_wait3");
    do_instr(OP_BR, CBR, 1'b1, 0, 0, "br_taken");
    do_instr(OP_BR, CBR, 1'b0, 0, 0, "br_not_taken");
    do_instr(OP_I,  CI,  1'b0, 2, 0, "i_type_fwait");
    do_instr(OP_ST, CST, 1'b0, 0, 1, "st_wait1");

    cur_tag = "st_reset";
    cyc_idx = 0;
    push(1'b1, OP_ST, 1'b0, e_fetch(1'b1));
    push(1'b1, OP_ST, 1'b0, base(3'd1));
    push(1'b1, OP_ST, 1'b0, e_exec(CST, 1'b0));
    drain();
    mem_ready = 1'b0;
    #1;
    chk(e_mem(CST, 1'b0));
    #1;
    reset_pulse("st_reset_mid_mem");

    cur_tag = "illegal";
    cyc_idx = 0;
    push(1'b1, OP_XX, 1'b0, e_fetch(1'b1));
    push(1'b1, OP_XX, 1'b0, base(3'd1));
    exp_ill = 1'b1;
    repeat (20) push(1'b1, OP_XX, 1'b0, base(3'd5));
    drain();
    reset_pulse("illegal_reset");

    cur_tag = "fetch_timeout";
    cyc_idx = 0;
    repeat (16) push(1'b0, OP_R, 1'b0, e_fetch(1'b0));
    exp_to = 1'b1;
    repeat (4) push(1'b1, OP_R, 1'b0, base(3'd5));
    drain();
    reset_pulse("timeout_reset");

    do_instr(OP_R,  CR,  1'b0, 15, 0,  "fetch_ready_16th");
    do_instr(OP_LD, CLD, 1'b0, 0,  15, "mem_ready_16th");

    cur_tag = "mem_timeout";
    cyc_idx = 0;
    push(1'b1, OP_ST, 1'b0, e_fetch(1'b1));
    push(1'b1, OP_ST, 1'b0, base(3'd1));
    push(1'b1, OP_ST, 1'b0, e_exec(CST, 1'b0));
    repeat (16) push(1'b0, OP_ST, 1'b0, e_mem(CST, 1'b0));
    exp_to = 1'b1;
    repeat (3) push(1'b1, OP_ST, 1'b0, base(3'd5));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
